// File: rtl/arbitro_memoria.sv
// arbitro_memoria: round-robin arbiter and sequencer placing two req/ack
// requesters in front of a single-port register memory with registered read
// data. Addresses at or above PROF are answered with an error ack and never
// reach the memory.
module arbitro_memoria #(
  parameter int DW   = 64,
  parameter int AW   = 6,
  parameter int PROF = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] ads0,
  input  logic [DW-1:0] din0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] ads1,
  input  logic [DW-1:0] din1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic [AW-1:0] mem_ads,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // One extra bit so that PROF == 2**AW is still representable.
  localparam logic [AW:0] ProfW = (AW+1)'(PROF);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic          ult_q, ult_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] mem_ads_q, mem_ads_d;
  logic [DW-1:0] mem_din_q, mem_din_d;

  logic          eff0, eff1;
  logic          pick1;
  logic          sel_we;
  logic [AW-1:0] sel_ads;
  logic [DW-1:0] sel_din;
  logic          out_of_range;

  // A requester is ignored in its own ack cycle so a held req is not
  // accepted twice. On a tie the requester that was not served last wins.
  assign eff0         = req0 & ~ack0_q;
  assign eff1         = req1 & ~ack1_q;
  assign pick1        = eff1 & (~eff0 | ~ult_q);
  assign sel_we       = pick1 ? we1  : we0;
  assign sel_ads      = pick1 ? ads1 : ads0;
  assign sel_din      = pick1 ? din1 : din0;
  assign out_of_range = {1'b0, sel_ads} >= ProfW;

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata   = rdata_q;
  assign busy    = (state_q != IDLE);
  assign mem_ads = mem_ads_q;
  assign mem_din = mem_din_q;
  // Write strobe only in EXEC, and gated by reset so a write caught by reset is dropped.
  assign mem_we  = (state_q == EXEC) & we_q & ~rst;

  // Next-state logic: arbitration in IDLE, memory access in EXEC, read capture in RESP.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    ult_d     = ult_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata_d   = rdata_q;
    mem_ads_d = mem_ads_q;
    mem_din_d = mem_din_q;
    unique case (state_q)
      IDLE: begin
        if (eff0 | eff1) begin
          gnt_d = pick1;
          ult_d = pick1;
          we_d  = sel_we;
          if (out_of_range) begin
            ack0_d  = ~pick1;
            err0_d  = ~pick1;
            ack1_d  = pick1;
            err1_d  = pick1;
            rdata_d = '0;
          end else begin
            mem_ads_d = sel_ads;
            mem_din_d = sel_din;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        if (we_q) begin
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        rdata_d = mem_dout;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      ult_q     <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata_q   <= '0;
      mem_ads_q <= '0;
      mem_din_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      ult_q     <= ult_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata_q   <= rdata_d;
      mem_ads_q <= mem_ads_d;
      mem_din_q <= mem_din_d;
    end
  end

endmodule
